// File: rtl/obj_pkg.sv
// Shared types for object_storage_scheduler: sweep FSM states, lane count and
// the per-group sideband carried through the read-latency alignment pipeline.
package obj_pkg;

    localparam int OBJ_LANES  = 4;
    // Wide enough for any practical OBJ_ADDR_WIDTH+1; narrower bases zero-extend.
    localparam int OBJ_BASE_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } sweep_state_t;

    typedef struct packed {
        logic [OBJ_LANES-1:0]  mask;
        logic [OBJ_BASE_W-1:0] base;
    } obj_group_t;

endpackage

// File: rtl/obj_write_arbiter.sv
// Two-requester arbiter for the single object_storage write port, plus the write
// register stage. OBJ_WRITE_RR_EN selects round-robin instead of physics priority.
module obj_write_arbiter #(
    parameter int OBJ_ADDR_WIDTH = 8,
    parameter int OBJ_WIDTH      = 32
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      sweep_busy_in,
    input  logic                      phys_wr_req_in,
    input  logic [OBJ_ADDR_WIDTH-1:0] phys_wr_addr_in,
    input  logic [OBJ_WIDTH-1:0]      phys_wr_obj_in,
    output logic                      phys_wr_gnt_out,
    input  logic                      cam_wr_req_in,
    input  logic [OBJ_ADDR_WIDTH-1:0] cam_wr_addr_in,
    input  logic [OBJ_WIDTH-1:0]      cam_wr_obj_in,
    output logic                      cam_wr_gnt_out,
    output logic                      wr_valid_out,
    output logic [OBJ_ADDR_WIDTH-1:0] wr_addr_out,
    output logic [OBJ_WIDTH-1:0]      wr_obj_out
);

    logic w_cam_elig;
    logic w_phys_gnt;
    logic w_cam_gnt;

`ifdef OBJ_WRITE_RR_EN
    logic r_last_cam;

    // Camera never competes during a sweep, so object creation cannot tear a sweep.
    always_comb begin
        w_cam_elig = cam_wr_req_in & ~sweep_busy_in;
        w_phys_gnt = phys_wr_req_in & (~w_cam_elig | r_last_cam);
        w_cam_gnt  = w_cam_elig & (~phys_wr_req_in | ~r_last_cam);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_last_cam <= 1'b1;
        end else if (w_phys_gnt) begin
            r_last_cam <= 1'b0;
        end else if (w_cam_gnt) begin
            r_last_cam <= 1'b1;
        end
    end
`else
    always_comb begin
        w_cam_elig = cam_wr_req_in & ~sweep_busy_in;
        w_phys_gnt = phys_wr_req_in;
        w_cam_gnt  = w_cam_elig & ~phys_wr_req_in;
    end
`endif

    always_comb begin
        phys_wr_gnt_out = w_phys_gnt;
        cam_wr_gnt_out  = w_cam_gnt;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_valid_out <= 1'b0;
            wr_addr_out  <= '0;
            wr_obj_out   <= '0;
        end else begin
            wr_valid_out <= w_phys_gnt | w_cam_gnt;
            if (w_phys_gnt) begin
                wr_addr_out <= phys_wr_addr_in;
                wr_obj_out  <= phys_wr_obj_in;
            end else if (w_cam_gnt) begin
                wr_addr_out <= cam_wr_addr_in;
                wr_obj_out  <= cam_wr_obj_in;
            end else begin
                wr_addr_out <= '0;
                wr_obj_out  <= '0;
            end
        end
    end

endmodule

// File: rtl/object_storage_scheduler.sv
// Sweeps the object table four lanes per cycle with read-latency alignment and
// arbitrates the storage write port (OBJ_WRITE_RR_EN selects round-robin writes).
`ifndef OBJ_COUNT
`define OBJ_COUNT 16
`endif
`ifndef OBJ_ADDR_WIDTH
`define OBJ_ADDR_WIDTH 8
`endif
`ifndef OBJ_WIDTH
`define OBJ_WIDTH 32
`endif

module object_storage_scheduler
    import obj_pkg::*;
#(
    parameter int OBJ_COUNT      = `OBJ_COUNT,
    parameter int OBJ_ADDR_WIDTH = `OBJ_ADDR_WIDTH,
    parameter int OBJ_WIDTH      = `OBJ_WIDTH,
    parameter int READ_LATENCY   = 2
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      sweep_start_in,
    output logic                      sweep_busy_out,
    output logic                      sweep_done_out,
    output logic                      rd_valid_out,
    output logic [OBJ_ADDR_WIDTH-1:0] rd_addrs_out [OBJ_LANES-1:0],
    input  logic [OBJ_WIDTH-1:0]      rd_objects_in [OBJ_LANES-1:0],
    output logic                      obj_valid_out,
    output logic [OBJ_WIDTH-1:0]      obj_data_out [OBJ_LANES-1:0],
    output logic [OBJ_LANES-1:0]      obj_mask_out,
    output logic [OBJ_ADDR_WIDTH-1:0] obj_base_addr_out,
    input  logic                      phys_wr_req_in,
    input  logic [OBJ_ADDR_WIDTH-1:0] phys_wr_addr_in,
    input  logic [OBJ_WIDTH-1:0]      phys_wr_obj_in,
    output logic                      phys_wr_gnt_out,
    input  logic                      cam_wr_req_in,
    input  logic [OBJ_ADDR_WIDTH-1:0] cam_wr_addr_in,
    input  logic [OBJ_WIDTH-1:0]      cam_wr_obj_in,
    output logic                      cam_wr_gnt_out,
    output logic                      wr_valid_out,
    output logic [OBJ_ADDR_WIDTH-1:0] wr_addr_out,
    output logic [OBJ_WIDTH-1:0]      wr_obj_out
);

    localparam int AW      = OBJ_ADDR_WIDTH;
    localparam int DRAIN_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    // One extra address bit so base+4 past the table end cannot wrap.
    localparam logic [AW:0] TABLE_END = (AW+1)'(OBJ_COUNT);
    localparam logic [AW:0] STEP      = (AW+1)'(OBJ_LANES);

    sweep_state_t            r_state;
    sweep_state_t            w_state_next;
    logic [AW:0]             r_base;
    logic [DRAIN_W-1:0]      r_drain_cnt;
    logic [READ_LATENCY-1:0] r_pipe_vld;
    obj_group_t              r_pipe_grp [READ_LATENCY];

    logic                    w_issue;
    logic                    w_busy;
    logic [OBJ_LANES-1:0]    w_mask;
    logic [AW:0]             w_lane [OBJ_LANES];
    logic                    w_out_vld;
    obj_group_t              w_out_grp;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (sweep_start_in) w_state_next = ISSUE;
            ISSUE:   if (r_base + STEP >= TABLE_END) w_state_next = DRAIN;
            DRAIN:   if (r_drain_cnt == DRAIN_W'(READ_LATENCY - 1)) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_issue        = (r_state == ISSUE);
        w_busy         = (r_state != IDLE);
        rd_valid_out   = w_issue;
        sweep_busy_out = w_busy;
        for (int unsigned i = 0; i < OBJ_LANES; i++) begin
            w_lane[i]       = r_base + (AW+1)'(i);
            w_mask[i]       = 1'b0;
            rd_addrs_out[i] = '0;
            if (w_issue && (w_lane[i] < TABLE_END)) begin
                w_mask[i]       = 1'b1;
                rd_addrs_out[i] = w_lane[i][AW-1:0];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_base      <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_base      <= w_issue ? r_base + STEP : '0;
            r_drain_cnt <= (r_state == DRAIN) ? r_drain_cnt + DRAIN_W'(1) : '0;
        end
    end

    // Sideband travels alongside the BRAM read so it lines up with rd_objects_in.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_pipe_vld <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                r_pipe_grp[i] <= '0;
            end
        end else begin
            r_pipe_vld[0]      <= w_issue;
            r_pipe_grp[0].mask <= w_mask;
            r_pipe_grp[0].base <= OBJ_BASE_W'(r_base);
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_grp[i] <= r_pipe_grp[i-1];
            end
        end
    end

    always_comb begin
        w_out_vld         = r_pipe_vld[READ_LATENCY-1];
        w_out_grp         = r_pipe_grp[READ_LATENCY-1];
        obj_valid_out     = w_out_vld;
        obj_mask_out      = '0;
        obj_base_addr_out = '0;
        sweep_done_out    = 1'b0;
        for (int unsigned i = 0; i < OBJ_LANES; i++) begin
            obj_data_out[i] = '0;
        end
        if (w_out_vld) begin
            obj_mask_out      = w_out_grp.mask;
            obj_base_addr_out = w_out_grp.base[AW-1:0];
            sweep_done_out    = (w_out_grp.base + OBJ_BASE_W'(OBJ_LANES)) >= OBJ_BASE_W'(OBJ_COUNT);
            for (int unsigned i = 0; i < OBJ_LANES; i++) begin
                obj_data_out[i] = rd_objects_in[i];
            end
        end
    end

    obj_write_arbiter #(
        .OBJ_ADDR_WIDTH (OBJ_ADDR_WIDTH),
        .OBJ_WIDTH      (OBJ_WIDTH)
    ) u_wr_arb (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .sweep_busy_in   (w_busy),
        .phys_wr_req_in  (phys_wr_req_in),
        .phys_wr_addr_in (phys_wr_addr_in),
        .phys_wr_obj_in  (phys_wr_obj_in),
        .phys_wr_gnt_out (phys_wr_gnt_out),
        .cam_wr_req_in   (cam_wr_req_in),
        .cam_wr_addr_in  (cam_wr_addr_in),
        .cam_wr_obj_in   (cam_wr_obj_in),
        .cam_wr_gnt_out  (cam_wr_gnt_out),
        .wr_valid_out    (wr_valid_out),
        .wr_addr_out     (wr_addr_out),
        .wr_obj_out      (wr_obj_out)
    );

endmodule

// File: tb/tb_object_storage_scheduler.sv
// Bench for object_storage_scheduler with 16- and 6-object tables; honours
// OBJ_WRITE_RR_EN for the expected write-arbitration order.
module tb_object_storage_scheduler;

    localparam int AW  = 6;
    localparam int W   = 16;
    localparam int RL  = 2;
    localparam int N16 = 16;
    localparam int N6  = 6;
    localparam int G16 = (N16 + 3) / 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic          start16 = 0, start6 = 0;
    logic          busy16, done16, rdv16, ov16, busy6, done6, rdv6, ov6;
    logic [AW-1:0] rd_addrs16 [3:0];
    logic [AW-1:0] rd_addrs6  [3:0];
    logic [W-1:0]  rd_obj16   [3:0];
    logic [W-1:0]  rd_obj6    [3:0];
    logic [W-1:0]  od16       [3:0];
    logic [W-1:0]  od6        [3:0];
    logic [3:0]    om16, om6;
    logic [AW-1:0] ob16, ob6;
    logic          preq = 0, creq = 0;
    logic [AW-1:0] paddr = '0, caddr = '0;
    logic [W-1:0]  pobj = '0, cobj = '0;
    logic          pgnt16, cgnt16, wv16, pgnt6, cgnt6, wv6;
    logic [AW-1:0] wa16, wa6;
    logic [W-1:0]  wo16, wo6;
    logic          z_req = 1'b0;
    logic [AW-1:0] z_addr = '0;
    logic [W-1:0]  z_obj = '0;

    object_storage_scheduler #(
        .OBJ_COUNT(N16), .OBJ_ADDR_WIDTH(AW), .OBJ_WIDTH(W), .READ_LATENCY(RL)
    ) u16 (
        .clk_in(clk), .rst_n_in(rst_n), .sweep_start_in(start16),
        .sweep_busy_out(busy16), .sweep_done_out(done16),
        .rd_valid_out(rdv16), .rd_addrs_out(rd_addrs16), .rd_objects_in(rd_obj16),
        .obj_valid_out(ov16), .obj_data_out(od16), .obj_mask_out(om16),
        .obj_base_addr_out(ob16),
        .phys_wr_req_in(preq), .phys_wr_addr_in(paddr), .phys_wr_obj_in(pobj),
        .phys_wr_gnt_out(pgnt16),
        .cam_wr_req_in(creq), .cam_wr_addr_in(caddr), .cam_wr_obj_in(cobj),
        .cam_wr_gnt_out(cgnt16),
        .wr_valid_out(wv16), .wr_addr_out(wa16), .wr_obj_out(wo16)
    );

    object_storage_scheduler #(
        .OBJ_COUNT(N6), .OBJ_ADDR_WIDTH(AW), .OBJ_WIDTH(W), .READ_LATENCY(RL)
    ) u6 (
        .clk_in(clk), .rst_n_in(rst_n), .sweep_start_in(start6),
        .sweep_busy_out(busy6), .sweep_done_out(done6),
        .rd_valid_out(rdv6), .rd_addrs_out(rd_addrs6), .rd_objects_in(rd_obj6),
        .obj_valid_out(ov6), .obj_data_out(od6), .obj_mask_out(om6),
        .obj_base_addr_out(ob6),
        .phys_wr_req_in(z_req), .phys_wr_addr_in(z_addr), .phys_wr_obj_in(z_obj),
        .phys_wr_gnt_out(pgnt6),
        .cam_wr_req_in(z_req), .cam_wr_addr_in(z_addr), .cam_wr_obj_in(z_obj),
        .cam_wr_gnt_out(cgnt6),
        .wr_valid_out(wv6), .wr_addr_out(wa6), .wr_obj_out(wo6)
    );

    function automatic logic [W-1:0] mem_f(input logic [AW-1:0] a);
        return 16'h5A00 + {10'd0, a} * 16'd7;
    endfunction

    // Storage model: read data appears two cycles after the address.
    logic [AW-1:0] s16_d1 [3:0];
    logic [AW-1:0] s16_d2 [3:0];
    logic [AW-1:0] s6_d1  [3:0];
    logic [AW-1:0] s6_d2  [3:0];
    always @(posedge clk) begin
        s16_d1 <= rd_addrs16;
        s16_d2 <= s16_d1;
        s6_d1  <= rd_addrs6;
        s6_d2  <= s6_d1;
    end
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rd_obj16[i] = mem_f(s16_d2[i]);
            rd_obj6[i]  = mem_f(s6_d2[i]);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: k = cycle index within a sweep (1 = first issue cycle), 0 = idle.
    function automatic int next_k(input int k, input int n, input logic st);
        int g;
        g = (n + 3) / 4;
        if (k >= 1 && k < g + RL) return k + 1;
        if (k == 0 && st) return 1;
        return 0;
    endfunction

    task automatic check_sweep(input string tag, input int k, input int n,
                               input logic rdv, input logic [4*AW-1:0] ad,
                               input logic ov, input logic [3:0] m, input logic [AW-1:0] b,
                               input logic dn, input logic bs, input logic [4*W-1:0] d);
        int g, a, j;
        logic erdv, eov, edn, ebs;
        logic [4*AW-1:0] ead;
        logic [3:0] em;
        logic [AW-1:0] eb;
        logic [4*W-1:0] ed;
        g    = (n + 3) / 4;
        erdv = (k >= 1 && k <= g);
        eov  = (k >= 1 + RL && k <= g + RL);
        edn  = eov && (k == g + RL);
        ebs  = (k >= 1 && k <= g + RL);
        ead  = '0; em = '0; eb = '0; ed = '0;
        for (int i = 0; i < 4; i++) begin
            a = 4 * (k - 1) + i;
            if (erdv && a < n) ead[i*AW +: AW] = AW'(a);
        end
        if (eov) begin
            j  = k - 1 - RL;
            eb = AW'(4 * j);
            for (int i = 0; i < 4; i++) begin
                a = 4 * j + i;
                em[i] = (a < n);
                ed[i*W +: W] = (a < n) ? mem_f(AW'(a)) : mem_f('0);
            end
        end
        chk({tag, "_rd_valid"}, rdv, erdv);
        chk({tag, "_rd_addrs"}, ad, ead);
        chk({tag, "_obj_valid"}, ov, eov);
        chk({tag, "_obj_mask"}, m, em);
        chk({tag, "_obj_base"}, b, eb);
        chk({tag, "_obj_data"}, d, ed);
        chk({tag, "_done"}, dn, edn);
        chk({tag, "_busy"}, bs, ebs);
    endtask

    int            k16 = 0, k6 = 0;
    logic          e_wv = 1'b0;
    logic [AW-1:0] e_wa = '0;
    logic [W-1:0]  e_wo = '0;
    logic          e_busy16;
    logic [1:0]    e_g16;
    assign e_busy16 = (k16 >= 1 && k16 <= G16 + RL);

`ifdef OBJ_WRITE_RR_EN
    logic turn_cam = 1'b1;
    function automatic logic [1:0] exp_gnt(input logic p, input logic c, input logic bsy, input logic tc);
        logic c_ok;
        c_ok = c && !bsy;
        if (p && c_ok) return tc ? 2'b10 : 2'b01;
        return {p, c_ok};
    endfunction
    assign e_g16 = exp_gnt(preq, creq, e_busy16, turn_cam);
`else
    function automatic logic [1:0] exp_gnt(input logic p, input logic c, input logic bsy);
        return {p, c && !bsy && !p};
    endfunction
    assign e_g16 = exp_gnt(preq, creq, e_busy16);
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k16  <= 0;
            k6   <= 0;
            e_wv <= 1'b0;
            e_wa <= '0;
            e_wo <= '0;
`ifdef OBJ_WRITE_RR_EN
            turn_cam <= 1'b1;
`endif
        end else begin
            k16  <= next_k(k16, N16, start16);
            k6   <= next_k(k6, N6, start6);
            e_wv <= |e_g16;
            e_wa <= e_g16[1] ? paddr : (e_g16[0] ? caddr : '0);
            e_wo <= e_g16[1] ? pobj  : (e_g16[0] ? cobj  : '0);
`ifdef OBJ_WRITE_RR_EN
            if (e_g16[1]) turn_cam <= 1'b0;
            else if (e_g16[0]) turn_cam <= 1'b1;
`endif
        end
    end

    always @(negedge clk) begin
        check_sweep("u16", k16, N16, rdv16,
                    {rd_addrs16[3], rd_addrs16[2], rd_addrs16[1], rd_addrs16[0]},
                    ov16, om16, ob16, done16, busy16, {od16[3], od16[2], od16[1], od16[0]});
        check_sweep("u6", k6, N6, rdv6,
                    {rd_addrs6[3], rd_addrs6[2], rd_addrs6[1], rd_addrs6[0]},
                    ov6, om6, ob6, done6, busy6, {od6[3], od6[2], od6[1], od6[0]});
        chk("u16_phys_gnt", pgnt16, e_g16[1]);
        chk("u16_cam_gnt", cgnt16, e_g16[0]);
        chk("u16_wr_valid", wv16, e_wv);
        chk("u16_wr_addr", wa16, e_wa);
        chk("u16_wr_obj", wo16, e_wo);
        chk("u6_wr_idle", {pgnt6, cgnt6, wv6, wa6, wo6}, '0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    int ngrp, ndone;
    logic [AW-1:0] prev_addr;
    logic exp_p;

    initial begin
        #1 rst_n = 1'b0;
        tick();
        chk("lit_rst_busy", busy16, 0);
        chk("lit_rst_wr_valid", wv16, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Both tables sweep together; c<n> = cycle n relative to the start pulse.
        start16 = 1; start6 = 1;
        tick(); start16 = 0; start6 = 0;                       // c1
        chk("lit_c1_rd_valid", rdv16, 1);
        chk("lit_c1_addr3", rd_addrs16[3], 3);
        chk("lit_c1_busy", busy16, 1);
        tick();                                                // c2
        chk("lit_c2_u6_addr0", rd_addrs6[0], 4);
        chk("lit_c2_u6_addr1", rd_addrs6[1], 5);
        chk("lit_c2_u6_addr2", rd_addrs6[2], 0);
        chk("lit_c2_u6_addr3", rd_addrs6[3], 0);
        tick();                                                // c3
        chk("lit_c3_addr0", rd_addrs16[0], 8);
        chk("lit_c3_obj_valid", ov16, 1);
        chk("lit_c3_mask", om16, 4'hF);
        chk("lit_c3_data1", od16[1], 16'h5A07);
        tick();                                                // c4
        chk("lit_c4_u6_mask", om6, 4'b0011);
        chk("lit_c4_u6_base", ob6, 4);
        chk("lit_c4_u6_done", done6, 1);
        chk("lit_c4_u6_data1", od6[1], 16'h5A23);
        chk("lit_c4_u6_data3", od6[3], 16'h5A00);
        tick();                                                // c5
        chk("lit_c5_u6_busy", busy6, 0);
        start6 = 1;
        tick(); start6 = 0;                                    // c6
        chk("lit_c6_u6_restart", busy6, 1);
        chk("lit_c6_done", done16, 1);
        chk("lit_c6_base", ob16, 12);
        tick();                                                // c7
        chk("lit_c7_busy", busy16, 0);
        repeat (4) tick();

        // Start pulse re-asserted mid-sweep is ignored.
        ngrp = 0; ndone = 0;
        start16 = 1;
        tick(); start16 = 0;
        tick(); start16 = 1;
        tick(); start16 = 0;
        for (int i = 0; i < 8; i++) begin
            ngrp  += int'(ov16);
            ndone += int'(done16);
            tick();
        end
        chk("lit_restart_groups", ngrp, 4);
        chk("lit_restart_done", ndone, 1);

        // Reset in cycle 2 of a sweep aborts it.
        start16 = 1;
        tick(); start16 = 0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("lit_abort_busy", busy16, 0);
        chk("lit_abort_rd_valid", rdv16, 0);
        chk("lit_abort_obj_valid", ov16, 0);
        tick();
        rst_n = 1'b1;
        ngrp = 0; ndone = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            ngrp  += int'(ov16);
            ndone += int'(done16);
        end
        chk("lit_abort_no_groups", ngrp, 0);
        chk("lit_abort_no_done", ndone, 0);

        // Both writers requesting continuously with the sweep idle.
        preq = 1; paddr = 16; pobj = 16'h1111;
        creq = 1; caddr = 40; cobj = 16'h2222;
        #1;
        for (int n = 0; n < 4; n++) begin
`ifdef OBJ_WRITE_RR_EN
            exp_p = (n % 2 == 0);
`else
            exp_p = 1'b1;
`endif
            chk("lit_arb_phys_gnt", pgnt16, exp_p);
            chk("lit_arb_cam_gnt", cgnt16, !exp_p);
            prev_addr = exp_p ? paddr : caddr;
            tick();
            chk("lit_arb_wr_addr", wa16, prev_addr);
            if (exp_p) paddr = paddr + 1'b1;
            else caddr = caddr + 1'b1;
            #1;
        end
        preq = 0; creq = 0;
        repeat (2) tick();

        // Camera request held across a sweep waits for busy to fall.
        start16 = 1;
        tick(); start16 = 0;                                   // c1
        creq = 1; caddr = 33; cobj = 16'h3333;
        #1;
        for (int i = 1; i <= 6; i++) begin
            chk("lit_cam_blocked", cgnt16, 0);
            tick();
        end
        chk("lit_cam_busy_fell", busy16, 0);                   // c7
        chk("lit_cam_gnt", cgnt16, 1);
        tick(); creq = 0;                                      // c8
        chk("lit_cam_wr_valid", wv16, 1);
        chk("lit_cam_wr_addr", wa16, 33);
        chk("lit_cam_wr_obj", wo16, 16'h3333);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
